// File: rtl/cordic_issue_scheduler.sv
// Round-robin issue scheduler that shares one free-running CORDIC pipeline between
// NUM_REQ requesters; a valid/tag delay line routes each result back to its owner.
module cordic_issue_scheduler #(
    parameter int  DATA_W      = 20,
    parameter int  NUM_REQ     = 4,
    parameter int  LATENCY     = 38,
    parameter int  OUTSTANDING = 8,
    localparam int ID_W        = $clog2(NUM_REQ),
    localparam int CNT_W       = $clog2(OUTSTANDING) + 1,
    localparam int INF_W       = $clog2(NUM_REQ * OUTSTANDING) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_x,
    input  logic [NUM_REQ*DATA_W-1:0] req_y,
    input  logic [NUM_REQ*DATA_W-1:0] req_z,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      drain,
    output logic [DATA_W-1:0]         pipe_x,
    output logic [DATA_W-1:0]         pipe_y,
    output logic [DATA_W-1:0]         pipe_z,
    input  logic [DATA_W-1:0]         pipe_res_x,
    input  logic [DATA_W-1:0]         pipe_res_y,
    input  logic [DATA_W-1:0]         pipe_res_z,
    output logic                      res_valid,
    output logic [ID_W-1:0]           res_id,
    output logic [DATA_W-1:0]         res_x,
    output logic [DATA_W-1:0]         res_y,
    output logic [DATA_W-1:0]         res_z,
    output logic [INF_W-1:0]          inflight,
    output logic                      idle
);

    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   outstanding_q [NUM_REQ];
    logic [CNT_W-1:0]   outstanding_d [NUM_REQ];
    logic [INF_W-1:0]   inflight_q, inflight_d;
    logic [DATA_W-1:0]  pipe_x_q, pipe_x_d, pipe_y_q, pipe_y_d, pipe_z_q, pipe_z_d;
    logic [LATENCY:0]   dl_valid_q, dl_valid_d;
    logic [ID_W-1:0]    dl_tag_q [LATENCY+1];
    logic [ID_W-1:0]    dl_tag_d [LATENCY+1];
    logic               res_valid_q, res_valid_d;
    logic [ID_W-1:0]    res_id_q, res_id_d;
    logic [DATA_W-1:0]  res_x_q, res_x_d, res_y_q, res_y_d, res_z_q, res_z_d;

    logic [NUM_REQ-1:0]   eligible;
    logic [NUM_REQ-1:0]   grant;
    logic [2*NUM_REQ-1:0] elig_rot;
    logic [ID_W:0]        scan_sum;
    logic [ID_W-1:0]      grant_id;
    logic                 transfer;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        eligible = '0;
        grant    = '0;
        grant_id = '0;
        scan_sum = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] && (outstanding_q[i] < CNT_W'(OUTSTANDING)) && !drain;
        end
        // Rotate so bit k is requester (rr_ptr + k); the lowest set bit wins.
        elig_rot = {eligible, eligible} >> rr_ptr_q;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (elig_rot[k]) begin
                scan_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
                if (scan_sum >= (ID_W+1)'(NUM_REQ)) begin
                    scan_sum = scan_sum - (ID_W+1)'(NUM_REQ);
                end
                grant_id = scan_sum[ID_W-1:0];
            end
        end
        if (|elig_rot[NUM_REQ-1:0]) begin
            grant[grant_id] = 1'b1;
        end
    end

    assign transfer = |(req_valid & grant);

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        pipe_x_d    = '0;
        pipe_y_d    = '0;
        pipe_z_d    = '0;
        dl_valid_d  = {dl_valid_q[LATENCY-1:0], transfer};
        dl_tag_d[0] = grant_id;
        for (int k = 1; k <= LATENCY; k++) begin
            dl_tag_d[k] = dl_tag_q[k-1];
        end
        if (transfer) begin
            rr_ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            pipe_x_d = req_x[grant_id*DATA_W +: DATA_W];
            pipe_y_d = req_y[grant_id*DATA_W +: DATA_W];
            pipe_z_d = req_z[grant_id*DATA_W +: DATA_W];
        end

        res_valid_d = dl_valid_q[LATENCY];
        res_id_d    = res_id_q;
        res_x_d     = res_x_q;
        res_y_d     = res_y_q;
        res_z_d     = res_z_q;
        if (dl_valid_q[LATENCY]) begin
            res_id_d = dl_tag_q[LATENCY];
            res_x_d  = pipe_res_x;
            res_y_d  = pipe_res_y;
            res_z_d  = pipe_res_z;
        end

        // Credits return in the res_valid cycle; issue and return together cancel.
        for (int i = 0; i < NUM_REQ; i++) begin
            outstanding_d[i] = outstanding_q[i];
            if (transfer && (grant_id == ID_W'(i)) && !(res_valid_q && (res_id_q == ID_W'(i)))) begin
                outstanding_d[i] = outstanding_q[i] + 1'b1;
            end else if (!(transfer && (grant_id == ID_W'(i))) && res_valid_q && (res_id_q == ID_W'(i))) begin
                outstanding_d[i] = outstanding_q[i] - 1'b1;
            end
        end
        inflight_d = inflight_q + INF_W'(transfer) - INF_W'(res_valid_q);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            inflight_q  <= '0;
            pipe_x_q    <= '0;
            pipe_y_q    <= '0;
            pipe_z_q    <= '0;
            dl_valid_q  <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_x_q     <= '0;
            res_y_q     <= '0;
            res_z_q     <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                outstanding_q[i] <= '0;
            end
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            inflight_q    <= inflight_d;
            outstanding_q <= outstanding_d;
            pipe_x_q      <= pipe_x_d;
            pipe_y_q      <= pipe_y_d;
            pipe_z_q      <= pipe_z_d;
            dl_valid_q    <= dl_valid_d;
            res_valid_q   <= res_valid_d;
            res_id_q      <= res_id_d;
            res_x_q       <= res_x_d;
            res_y_q       <= res_y_d;
            res_z_q       <= res_z_d;
        end
    end

    // NOTE: the tag line is left unreset; tags are only consumed where dl_valid_q is set.
    always_ff @(posedge clk) begin
        dl_tag_q <= dl_tag_d;
    end

    assign req_ready = grant;
    assign pipe_x    = pipe_x_q;
    assign pipe_y    = pipe_y_q;
    assign pipe_z    = pipe_z_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_x     = res_x_q;
    assign res_y     = res_y_q;
    assign res_z     = res_z_q;
    assign inflight  = inflight_q;
    assign idle      = (inflight_q == '0);

endmodule

// File: tb/tb_cordic_issue_scheduler.sv
// Self-checking bench for cordic_issue_scheduler: a LATENCY-deep register chain stands in
// for the CORDIC pipeline, and a queue-based scoreboard predicts grants and returns.
module tb_cordic_issue_scheduler;

    localparam int DATA_W      = 20;
    localparam int NUM_REQ     = 4;
    localparam int LATENCY     = 38;
    localparam int OUTSTANDING = 8;
    localparam int ID_W        = $clog2(NUM_REQ);
    localparam int INF_W       = $clog2(NUM_REQ * OUTSTANDING) + 1;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*DATA_W-1:0] req_x = '0;
    logic [NUM_REQ*DATA_W-1:0] req_y = '0;
    logic [NUM_REQ*DATA_W-1:0] req_z = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      drain = 1'b0;
    logic [DATA_W-1:0]         pipe_x, pipe_y, pipe_z;
    logic [DATA_W-1:0]         pipe_res_x, pipe_res_y, pipe_res_z;
    logic                      res_valid;
    logic [ID_W-1:0]           res_id;
    logic [DATA_W-1:0]         res_x, res_y, res_z;
    logic [INF_W-1:0]          inflight;
    logic                      idle;

    cordic_issue_scheduler #(
        .DATA_W(DATA_W), .NUM_REQ(NUM_REQ), .LATENCY(LATENCY), .OUTSTANDING(OUTSTANDING)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid),
        .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_ready(req_ready), .drain(drain),
        .pipe_x(pipe_x), .pipe_y(pipe_y), .pipe_z(pipe_z),
        .pipe_res_x(pipe_res_x), .pipe_res_y(pipe_res_y), .pipe_res_z(pipe_res_z),
        .res_valid(res_valid), .res_id(res_id), .res_x(res_x), .res_y(res_y), .res_z(res_z),
        .inflight(inflight), .idle(idle)
    );

    always #5 clk = ~clk;

    // Stand-in pipeline: returns exactly what entered LATENCY cycles earlier.
    logic [3*DATA_W-1:0] pipe_sr [LATENCY];
    always @(posedge clk) begin
        pipe_sr[0] <= {pipe_x, pipe_y, pipe_z};
        for (int i = 1; i < LATENCY; i++) pipe_sr[i] <= pipe_sr[i-1];
    end
    assign {pipe_res_x, pipe_res_y, pipe_res_z} = pipe_sr[LATENCY-1];

    typedef struct {
        int                id;
        logic [DATA_W-1:0] x, y, z;
        longint            ret;
    } op_t;

    op_t                 sb[$];
    int                  m_rr = 0;
    longint              cyc = 0;
    logic [3*DATA_W-1:0] m_pipe = '0;
    logic [3*DATA_W-1:0] m_res = '0;
    logic [ID_W-1:0]     m_rid = '0;
    int                  n_checks = 0;
    int                  n_pass = 0;

    function automatic int count_out(int id);
        int n;
        n = 0;
        foreach (sb[k]) if (sb[k].id == id) n++;
        return n;
    endfunction

    function automatic logic [NUM_REQ-1:0] exp_grant();
        logic [NUM_REQ-1:0] g;
        int i;
        g = '0;
        if (drain) return g;
        for (int k = 0; k < NUM_REQ; k++) begin
            i = (m_rr + k) % NUM_REQ;
            if (req_valid[i] && count_out(i) < OUTSTANDING) begin
                g[i] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    // One clock cycle: compare all outputs against the scoreboard, then advance it.
    task automatic step();
        logic [NUM_REQ-1:0]  g;
        logic [3*DATA_W-1:0] er;
        logic [ID_W-1:0]     eid;
        bit                  ret_now;
        int                  gid;
        op_t                 op;
        @(negedge clk);
        g       = exp_grant();
        ret_now = (sb.size() > 0) && (sb[0].ret == cyc);
        er      = ret_now ? {sb[0].x, sb[0].y, sb[0].z} : m_res;
        eid     = ret_now ? ID_W'(sb[0].id) : m_rid;
        if (!rst) begin
            n_checks++;
            if (req_ready !== g) $display("FAIL grant @%0d: req_ready=%b expected %b", cyc, req_ready, g);
            else n_pass++;
            n_checks++;
            if (res_valid !== ret_now) $display("FAIL res_valid @%0d: got %b expected %b", cyc, res_valid, ret_now);
            else n_pass++;
            n_checks++;
            if ({res_id, res_x, res_y, res_z} !== {eid, er})
                $display("FAIL result @%0d: id/xyz=%0h/%0h expected %0h/%0h", cyc, res_id, {res_x, res_y, res_z}, eid, er);
            else n_pass++;
            n_checks++;
            if ({pipe_x, pipe_y, pipe_z} !== m_pipe)
                $display("FAIL pipe_in @%0d: got %0h expected %0h", cyc, {pipe_x, pipe_y, pipe_z}, m_pipe);
            else n_pass++;
            n_checks++;
            if (inflight !== INF_W'(sb.size()) || idle !== (sb.size() == 0))
                $display("FAIL inflight @%0d: got %0d/idle %b expected %0d", cyc, inflight, idle, sb.size());
            else n_pass++;
        end
        @(posedge clk);
        if (rst) begin
            sb.delete();
            m_rr = 0; m_pipe = '0; m_res = '0; m_rid = '0;
        end else begin
            if (ret_now) begin
                m_res = er; m_rid = eid;
                void'(sb.pop_front());
            end
            m_pipe = '0;
            if (g != '0) begin
                gid = 0;
                for (int i = 0; i < NUM_REQ; i++) if (g[i]) gid = i;
                op.id  = gid;
                op.x   = req_x[gid*DATA_W +: DATA_W];
                op.y   = req_y[gid*DATA_W +: DATA_W];
                op.z   = req_z[gid*DATA_W +: DATA_W];
                op.ret = cyc + 2 + LATENCY;
                sb.push_back(op);
                m_pipe = {op.x, op.y, op.z};
                m_rr   = (gid + 1) % NUM_REQ;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_x[i*DATA_W +: DATA_W] = DATA_W'($urandom);
            req_y[i*DATA_W +: DATA_W] = DATA_W'($urandom);
            req_z[i*DATA_W +: DATA_W] = DATA_W'($urandom);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; drain = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        req_valid = '0;
        drain     = 1'b0;
        for (int k = 0; k < 200 && !idle; k++) step();
        n_checks++;
        if (idle !== 1'b1) $display("FAIL idle_timeout: idle=%b inflight=%0d expected idle=1", idle, inflight);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; drain = 1'b0;
        step();
        n_checks++;
        if ({req_ready, pipe_x, pipe_y, pipe_z, res_valid, res_id, res_x, res_y, res_z, inflight, idle} !==
            {{NUM_REQ{1'b0}}, {(6*DATA_W+ID_W+1+INF_W){1'b0}}, 1'b1})
            $display("FAIL reset_values: ready=%b pipe=%0h rv=%b id=%0d res=%0h inflight=%0d idle=%b",
                     req_ready, {pipe_x, pipe_y, pipe_z}, res_valid, res_id, {res_x, res_y, res_z}, inflight, idle);
        else n_pass++;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_issue();
        do_reset();
        rand_ops();
        req_valid = 4'b0100;
        req_x[2*DATA_W +: DATA_W] = 20'h10000;
        req_y[2*DATA_W +: DATA_W] = 20'h08000;
        req_z[2*DATA_W +: DATA_W] = 20'h02000;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) $display("FAIL single_grant: got %b expected 0100", req_ready);
        else n_pass++;
        step();
        req_valid = '0;
        n_checks++;
        if (pipe_x !== 20'h10000) $display("FAIL single_pipe_x: got %0h expected 10000", pipe_x);
        else n_pass++;
        for (int off = 1; off <= 41; off++) begin
            n_checks++;
            if (inflight !== ((off <= 40) ? INF_W'(1) : INF_W'(0)))
                $display("FAIL single_inflight T+%0d: got %0d", off, inflight);
            else n_pass++;
            if (off == 40) begin
                n_checks++;
                if (res_valid !== 1'b1 || res_id !== 2'd2 || res_x !== 20'h10000)
                    $display("FAIL single_result: rv=%b id=%0d x=%0h expected 1/2/10000", res_valid, res_id, res_x);
                else n_pass++;
            end
            step();
        end
    endtask

    task automatic test_round_robin();
        logic [NUM_REQ-1:0] exp_g;
        int n_grants, n_res;
        do_reset();
        n_grants = 0;
        n_res    = 0;
        req_valid = '1;
        for (int k = 0; k < 120; k++) begin
            rand_ops();
            #1;
            if (res_valid) begin
                n_checks++;
                if (res_id !== ID_W'(n_res % NUM_REQ))
                    $display("FAIL rr_res_order: id=%0d expected %0d", res_id, n_res % NUM_REQ);
                else n_pass++;
                n_res++;
            end
            if (req_ready != '0) begin
                exp_g = '0;
                exp_g[n_grants % NUM_REQ] = 1'b1;
                n_checks++;
                if (req_ready !== exp_g) $display("FAIL rr_order: got %b expected %b", req_ready, exp_g);
                else n_pass++;
                n_grants++;
            end
            step();
        end
        wait_idle();
    endtask

    task automatic test_credit_limit();
        logic [NUM_REQ-1:0] exp_g;
        do_reset();
        for (int k = 0; k <= 41; k++) begin
            rand_ops();
            req_valid = 4'b0010;
            #1;
            exp_g = (k < OUTSTANDING || k == 41) ? 4'b0010 : 4'b0000;
            n_checks++;
            if (req_ready !== exp_g) $display("FAIL credit_k%0d: got %b expected %b", k, req_ready, exp_g);
            else n_pass++;
            if (k == 40) begin
                n_checks++;
                if (res_valid !== 1'b1 || res_id !== 2'd1)
                    $display("FAIL credit_first_return: rv=%b id=%0d expected 1/1", res_valid, res_id);
                else n_pass++;
            end
            step();
        end
        wait_idle();
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int k = 0; k <= 42; k++) begin
            rand_ops();
            req_valid = (k < 3 || k == 40) ? 4'b0001 : 4'b0000;
            #1;
            if (k == 40) begin
                n_checks++;
                if (res_valid !== 1'b1 || res_id !== 2'd0 || req_ready !== 4'b0001 || inflight !== INF_W'(3))
                    $display("FAIL simul_setup: rv=%b id=%0d ready=%b inflight=%0d expected 1/0/0001/3",
                             res_valid, res_id, req_ready, inflight);
                else n_pass++;
            end
            if (k == 41) begin
                n_checks++;
                if (inflight !== INF_W'(3)) $display("FAIL simul_inflight: got %0d expected 3", inflight);
                else n_pass++;
            end
            step();
        end
        wait_idle();
    endtask

    task automatic test_drain();
        int pulses;
        do_reset();
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            rand_ops();
            step();
        end
        drain = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0000) $display("FAIL drain_same_cycle: got %b expected 0000", req_ready);
        else n_pass++;
        pulses = 0;
        for (int k = 0; k < 80 && !idle; k++) begin
            step();
            if (res_valid) pulses++;
        end
        n_checks++;
        if (pulses !== 5 || idle !== 1'b1) $display("FAIL drain_returns: pulses=%0d idle=%b expected 5/1", pulses, idle);
        else n_pass++;
        drain = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) $display("FAIL drain_resume: got %b expected 0010", req_ready);
        else n_pass++;
        for (int k = 0; k < 6; k++) begin
            rand_ops();
            step();
        end
        wait_idle();
    endtask

    task automatic test_reset_midflight();
        int pulses;
        do_reset();
        req_valid = '1;
        for (int k = 0; k < 10; k++) begin
            rand_ops();
            step();
        end
        rst = 1'b1;
        req_valid = '0;
        step();
        rst = 1'b0;
        n_checks++;
        if (inflight !== '0 || idle !== 1'b1) $display("FAIL midreset_state: inflight=%0d idle=%b expected 0/1", inflight, idle);
        else n_pass++;
        pulses = 0;
        for (int k = 0; k < 60; k++) begin
            step();
            if (res_valid) pulses++;
        end
        n_checks++;
        if (pulses !== 0) $display("FAIL midreset_stale: res_valid pulses=%0d expected 0", pulses);
        else n_pass++;
        req_valid = '1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) $display("FAIL midreset_rr: got %b expected 0001", req_ready);
        else n_pass++;
        step();
        wait_idle();
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 600; k++) begin
            rand_ops();
            req_valid = NUM_REQ'($urandom) | NUM_REQ'($urandom);
            drain     = ($urandom_range(0, 15) == 0);
            step();
        end
        wait_idle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_issue();
        test_round_robin();
        test_credit_limit();
        test_simultaneous();
        test_drain();
        test_reset_midflight();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
